dsp_mac_sequencer: RTL
======================

# dsp_mac_sequencer

Control-side initiator for one DSP48A1-style slice. It drives the slice's register clock enables, the P-register reset and the OPMODE word. It also issues sample/coefficient read addresses so the slice performs an N-tap multiply-accumulate. It sits between the coefficient/sample memories and the slice's pipeline registers (A/B, M, P) and reports completion with a one-cycle done pulse.

## Interface
- AW, 8: read-address width; maximum tap count is 2^AW.
- NW, 9: width of TAPS_LEN (AW+1, so a full 2^AW taps is representable).
- CLK  in  1  clock; every register rises on posedge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- ABORT  in  1  synchronous cancel; valid in any non-IDLE state.
- TAPS_LEN  in  NW  number of taps N; sampled with START.
- ADDR  out  AW  read address to sample and coefficient memories (1-cycle read latency).
- CE_AB  out  1  enable for the slice's A/B input registers.
- CE_M  out  1  enable for the M register.
- CE_P  out  1  enable for the P register.
- RST_P  out  1  synchronous clear of the P register (one-cycle pulse).
- OPMODE  out  8  slice OPMODE: 8'h01 = X=M, Z=0 (first tap); 8'h09 = X=M, Z=P (accumulate).
- BUSY  out  1  high from the edge after START until DONE deasserts.
- DONE  out  1  one-cycle pulse; P holds the final sum while DONE is high.

## Operation
- States: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: START=1 latches N, clears the issue counter and pulses RST_P next cycle.
    - N>0 → ISSUE.
    - N=0 → FIN. P is cleared by RST_P, no CE pulses occur, and DONE follows.
  - ISSUE: ADDR = issue count, 0..N-1, one per cycle. After N-1 has been issued → DRAIN.
  - DRAIN: waits until the enable pipeline is empty. The final P capture → FIN.
  - FIN: DONE=1 for one cycle → IDLE.
- Enable pipeline: a 3-stage valid shift register fed by "address issued this cycle".
  - Stage 1 drives CE_AB; the memory data arrives with it.
  - Stage 2 drives CE_M.
  - Stage 3 drives CE_P.
  - A first-tap flag travels alongside the valid bits. OPMODE = 8'h01 on the cycle CE_P is high for tap 0, and 8'h09 otherwise.
- Outside active capture cycles, all CEs are 0 and OPMODE = 8'h09. The slice registers therefore hold their values.
- START while BUSY is ignored. TAPS_LEN > 2^AW is saturated to 2^AW.
- ABORT in ISSUE/DRAIN/FIN:
  - next state is IDLE;
  - the valid pipeline is flushed to zero;
  - no DONE is produced;
  - P is left undefined for software, and the next run clears it with RST_P.
- ABORT and START in the same cycle while IDLE: START wins.
- Asynchronous reset (RST=0) at any time forces the following, regardless of the clock:
  - state = IDLE;
  - ADDR=0, CE_AB=CE_M=CE_P=0, RST_P=0;
  - OPMODE=8'h09, BUSY=0, DONE=0;
  - the valid pipeline is cleared.

## Timing
- The START-sampling edge is edge k.
- Edge k+1: RST_P is high for that cycle and ADDR=0 is presented.
- ADDR i is presented on edge k+1+i.
- CE_AB for tap i is high in cycle k+2+i, CE_M in k+3+i and CE_P in k+4+i.
- The final tap is captured in P at edge k+N+4. DONE is high in the cycle starting at that edge, and P then holds the full sum.
- Throughput is one tap per cycle with no bubbles. The next START is accepted the cycle after DONE.
- For N=0: RST_P is high at edge k+1 and DONE is high at edge k+2.
- All outputs are registered; no combinational path runs from any input to any output.

## Structure
- Shared package dsp48_pkg holds:
  - OPMODE constants OPM_M_ZERO=8'h01 and OPM_M_ACC=8'h09;
  - the state enum (IDLE/ISSUE/DRAIN/FIN);
  - the slice pipeline depth constant (3).
- One sub-module, ce_pipe: a parameterised-depth valid/flag shift register with async active-low clear. It is reused for the CE_AB/CE_M/CE_P generation.
- The top-level module contains the FSM, the issue counter and the output registers.

## Test plan
- Reset check: hold RST=0 mid-ISSUE → all outputs read their reset values immediately, with no clock edge needed. Release RST → the block is in IDLE and BUSY=0.
- N=4 run, with the bench model's slice using A=i+1 and B=2:
  - ADDR reads 0,1,2,3 on consecutive cycles;
  - CE_P is high for 4 consecutive cycles, with OPMODE 01,09,09,09;
  - DONE is high 8 cycles after the START edge;
  - P=20.
- N=0 → RST_P pulses and DONE arrives 2 cycles after START, with no CE_AB, CE_M or CE_P activity.
- N=256 with AW=8:
  - ADDR wraps through 0..255 exactly once;
  - DONE arrives after 260 cycles;
  - a START pulsed mid-run is ignored.
- ABORT at the third issued address of an N=10 run → next cycle IDLE, all CEs 0, and no DONE. A following START with N=2 gives the correct sum, P cleared first.
- Back-to-back runs: START on the cycle after DONE → accepted. The second sum is independent of the first (OPMODE 01 on its first CE_P).

Source files
------------

// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48A1-style MAC sequencer.
//   OPM_M_ZERO / OPM_M_ACC : OPMODE words for first tap (P = M) and accumulate (P = P + M)
//   SLICE_DEPTH            : register stages between read address and P (A/B, M, P)
//   seq_state_e            : sequencer FSM states
package dsp48_pkg;

  localparam logic [7:0] OPM_M_ZERO = 8'h01;
  localparam logic [7:0] OPM_M_ACC  = 8'h09;

  localparam int unsigned SLICE_DEPTH = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } seq_state_e;

endpackage

// File: rtl/ce_pipe.sv
// Valid/first-tap shift register that generates the slice clock enables.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low clear
//   flush_i  : synchronous clear of every stage (abort)
//   vld_i    : a read address was presented this cycle
//   first_i  : that address belongs to tap 0
//   vld_o    : per-stage valid bits, vld_o[0] is the earliest stage
//   first_o  : last stage carries tap 0
module ce_pipe
  import dsp48_pkg::*;
#(
  parameter int unsigned Depth = SLICE_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic             first_i,
  output logic [Depth-1:0] vld_o,
  output logic             first_o
);

  logic [Depth-1:0] vld_q;
  logic [Depth-1:0] first_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      first_q <= '0;
    end else if (flush_i) begin
      vld_q   <= '0;
      first_q <= '0;
    end else begin
      vld_q   <= {vld_q[Depth-2:0], vld_i};
      first_q <= {first_q[Depth-2:0], first_i & vld_i};
    end
  end

  assign vld_o   = vld_q;
  assign first_o = first_q[Depth-1] & vld_q[Depth-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Control-side sequencer for one DSP48A1-style slice performing an N-tap MAC.
//   CLK, RST      : clock, asynchronous active-low reset
//   start_i       : start request, taken only when idle and not busy
//   abort_i       : synchronous cancel of a running sequence
//   taps_len_i    : tap count N (saturated to 2^AW), sampled with start_i
//   addr_o        : sample/coefficient read address (memories have 1-cycle latency)
//   ce_ab_o/ce_m_o/ce_p_o : slice register clock enables
//   rst_p_o       : one-cycle synchronous clear of P at the start of a run
//   opmode_o      : 8'h01 on tap 0's P capture, 8'h09 otherwise
//   busy_o        : high from the accepting edge until done_o drops
//   done_o        : one-cycle pulse, P holds the final sum
module dsp_mac_sequencer
  import dsp48_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned NW = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [NW-1:0] taps_len_i,
  output logic [AW-1:0] addr_o,
  output logic          ce_ab_o,
  output logic          ce_m_o,
  output logic          ce_p_o,
  output logic          rst_p_o,
  output logic [7:0]    opmode_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [NW-1:0] MaxTaps = NW'(2 ** AW);

  seq_state_e state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d;
  logic          first_q, first_d;
  logic          start_seen_q, start_seen_d;
  logic          rst_p_q, rst_p_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic                   flush;
  logic [NW-1:0]          taps_sat;
  logic [SLICE_DEPTH-1:0] pipe_vld;
  logic                   pipe_first;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    addr_d       = addr_q;
    vld_d        = 1'b0;
    first_d      = 1'b0;
    start_seen_d = 1'b0;
    // P is cleared the cycle after the accepting edge, alongside ADDR 0.
    rst_p_d      = start_seen_q;
    done_d       = 1'b0;
    flush        = 1'b0;
    taps_sat     = (taps_len_i > MaxTaps) ? MaxTaps : taps_len_i;

    unique case (state_q)
      StIdle: begin
        // busy_q is still high during the DONE cycle, so a START there is ignored.
        if (start_i && !busy_q) begin
          n_d          = taps_sat;
          cnt_d        = '0;
          start_seen_d = 1'b1;
          state_d      = (taps_sat == '0) ? StFin : StIssue;
        end
      end
      StIssue: begin
        vld_d   = 1'b1;
        addr_d  = cnt_q[AW-1:0];
        first_d = (cnt_q == '0);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Last tap is in M this cycle; it reaches P one edge after FIN.
        if (!vld_q && !pipe_vld[0]) begin
          state_d = StFin;
        end
      end
      StFin: begin
        // For N=0 wait out the RST_P pulse so DONE lands after P is cleared.
        if (!start_seen_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d      = StIdle;
      vld_d        = 1'b0;
      first_d      = 1'b0;
      start_seen_d = 1'b0;
      rst_p_d      = 1'b0;
      done_d       = 1'b0;
      flush        = 1'b1;
    end

    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      n_q          <= '0;
      addr_q       <= '0;
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      start_seen_q <= 1'b0;
      rst_p_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      first_q      <= first_d;
      start_seen_q <= start_seen_d;
      rst_p_q      <= rst_p_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  ce_pipe #(
    .Depth (SLICE_DEPTH)
  ) u_ce_pipe (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .flush_i (flush),
    .vld_i   (vld_q),
    .first_i (first_q),
    .vld_o   (pipe_vld),
    .first_o (pipe_first)
  );

  assign addr_o   = addr_q;
  assign ce_ab_o  = pipe_vld[0];
  assign ce_m_o   = pipe_vld[1];
  assign ce_p_o   = pipe_vld[2];
  assign rst_p_o  = rst_p_q;
  assign opmode_o = pipe_first ? OPM_M_ZERO : OPM_M_ACC;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
